// File: rtl/icache_refill_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : icache_refill_responder                                      |
// | Description : Memory-side responder for the icache miss/refill handshake.  |
// |               Latches a missing line address, fetches LINE_WORDS 32-bit    |
// |               words over a req/ack memory port, and returns the assembled  |
// |               line with a one-cycle readready pulse.                       |
// | Options     : `define CRITICAL_WORD_FIRST_EN to fetch in wrap order        |
// |               starting at the requested word (line layout is unchanged).   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module icache_refill_responder #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     readmiss,
  input  logic [ADDR_W-1:0]        address,
  output logic                     readready,
  output logic [32*LINE_WORDS-1:0] datareadmiss,
  output logic                     busy,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_rdata
);

  localparam int c_OFF_W  = $clog2(LINE_WORDS);
  localparam int c_CNT_W  = c_OFF_W + 1;
  localparam int c_LINE_W = 32 * LINE_WORDS;
  // Byte-offset plus word-offset bits of an address within one line.
  localparam logic [ADDR_W-1:0]  c_LOW_MASK = ADDR_W'(LINE_WORDS * 4 - 1);
  localparam logic [c_CNT_W-1:0] c_LAST     = c_CNT_W'(LINE_WORDS - 1);
  localparam logic [c_CNT_W-1:0] c_ONE      = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_FETCH     = 2'd1,
    S_RESP      = 2'd2,
    S_WAIT_DROP = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_W-1:0]     r_base;
  logic [c_OFF_W-1:0]    r_start;
  logic [c_OFF_W-1:0]    w_start_in;
  logic [c_OFF_W-1:0]    w_slot;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [c_LINE_W-1:0]   r_stage;
  logic [c_LINE_W-1:0]   w_stage_next;
  logic [c_LINE_W-1:0]   r_line;
  logic                  w_accept;
  logic                  w_take;
  logic                  w_last;

`ifdef CRITICAL_WORD_FIRST_EN
  assign w_start_in = address[c_OFF_W+1:2];
`else
  assign w_start_in = '0;
`endif

  // Slot index wraps naturally in c_OFF_W bits, giving the modulo-LINE_WORDS order.
  assign w_slot   = r_start + r_cnt[c_OFF_W-1:0];
  assign w_accept = (r_state == S_IDLE) && readmiss;
  assign w_take   = (r_state == S_FETCH) && mem_ack;
  assign w_last   = w_take && (r_cnt == c_LAST);

  // State register; async reset aborts any fill in progress.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    readready    = 1'b0;
    busy         = 1'b1;
    mem_req      = 1'b0;
    mem_addr     = '0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (readmiss) begin
          w_state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = r_base + (ADDR_W'(w_slot) << 2);
        if (w_last) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        readready    = 1'b1;
        w_state_next = S_WAIT_DROP;
      end
      S_WAIT_DROP: begin
        // A still-high readmiss here is the icache lagging, not a new miss.
        if (!readmiss) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Staging line with the current word merged into its slot.
  always_comb begin
    w_stage_next = r_stage;
    for (int i = 0; i < LINE_WORDS; i++) begin
      if (w_take && (w_slot == c_OFF_W'(i))) begin
        w_stage_next[32*i +: 32] = mem_rdata;
      end
    end
  end

  // Request latch, word counter, staging and the published line.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_base  <= '0;
      r_start <= '0;
      r_cnt   <= '0;
      r_stage <= '0;
      r_line  <= '0;
    end else begin
      if (w_accept) begin
        r_base  <= address & ~c_LOW_MASK;
        r_start <= w_start_in;
        r_cnt   <= '0;
      end
      if (w_take) begin
        r_stage <= w_stage_next;
        r_cnt   <= r_cnt + c_ONE;
      end
      // The visible line only changes when a whole fill has landed.
      if (w_last) begin
        r_line <= w_stage_next;
      end
    end
  end

  assign datareadmiss = r_line;

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_icache_refill_responder                                   |
// | Description : Self-checking bench for icache_refill_responder: table of    |
// |               directed fills, reset sequences and randomized fills checked |
// |               against a line-level reference model.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_icache_refill_responder;

  localparam int LW = 4;

  logic         Clk;
  logic         Rst_n;
  logic         readmiss;
  logic [31:0]  address;
  logic         readready;
  logic [127:0] datareadmiss;
  logic         busy;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_rdata;

  icache_refill_responder #(
    .LINE_WORDS (LW),
    .ADDR_W     (32)
  ) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .readmiss     (readmiss),
    .address      (address),
    .readready    (readready),
    .datareadmiss (datareadmiss),
    .busy         (busy),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int           n_pass  = 0;
  int           n_total = 0;
  logic [127:0] prev_line;

  typedef struct {
    logic [31:0]  addr;
    int           period;
    int           hold;
    logic [31:0]  seed;
    int           exp_ready;
    logic [127:0] exp_line;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One complete miss transaction, starting and ending at a negedge with the DUT idle.
  // Memory word at line index i returns seed+i. period>0: ack every period-th cycle,
  // period==0: random ack. hold: cycles readmiss stays high after readready.
  task automatic run_fill(input logic [31:0] addr, input int period, input int hold,
                          input logic [31:0] seed, input bit drop_early, output int t_ready);
    logic [31:0]  base;
    int           start;
    int           acks;
    int           h;
    bit           done;
    bit           ack;
    logic [127:0] exp_line;
    base = addr & ~32'hF;
`ifdef CRITICAL_WORD_FIRST_EN
    start = int'(addr[3:2]);
`else
    start = 0;
`endif
    for (int i = 0; i < LW; i++) exp_line[32*i +: 32] = seed + 32'(i);
    readmiss = 1'b1;
    address  = addr;
    mem_ack  = 1'b0;
    acks     = 0;
    done     = 1'b0;
    t_ready  = -1;
    for (int t = 1; t <= 200 && !done; t++) begin
      @(negedge Clk);
      address = $urandom;
      if (drop_early && t == 2) readmiss = 1'b0;
      check("busy_fill", busy, 1);
      if (acks < LW) begin
        check("mem_req", mem_req, 1);
        check("mem_addr", mem_addr, base + 32'(((start + acks) % LW) * 4));
        check("readready_early", readready, 0);
        check("line_stable", datareadmiss, prev_line);
        ack       = (period > 0) ? ((t % period) == 0) : 1'($urandom_range(0, 1));
        mem_ack   = ack;
        mem_rdata = ack ? (seed + 32'(mem_addr[3:2])) : $urandom;
        if (ack) acks++;
      end else begin
        check("readready", readready, 1);
        check("mem_req_drop", mem_req, 0);
        check("datareadmiss", datareadmiss, exp_line);
        t_ready   = t;
        done      = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
      end
    end
    check("fill_done", done, 1);
    if (done) begin
      prev_line = exp_line;
      h = drop_early ? 0 : hold;
      for (int k = 1; k <= h; k++) begin
        @(negedge Clk);
        check("wd_busy", busy, 1);
        check("wd_req", mem_req, 0);
        check("wd_ready", readready, 0);
        check("wd_line", datareadmiss, exp_line);
      end
      readmiss = 1'b0;
      mem_ack  = 1'b0;
      if (h == 0) begin
        @(negedge Clk);
        check("wd0_busy", busy, 1);
        check("wd0_ready", readready, 0);
      end
      @(negedge Clk);
      check("idle_busy", busy, 0);
      check("idle_req", mem_req, 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t_ready;
    vecs[0] = '{32'h0000_1234, 1, 0, 32'h0000_00A0, 5,  {32'hA3, 32'hA2, 32'hA1, 32'hA0}};
    vecs[1] = '{32'h0000_5678, 3, 0, 32'h0000_0100, 13, {32'h103, 32'h102, 32'h101, 32'h100}};
    vecs[2] = '{32'h0000_1FF0, 1, 2, 32'h0000_0055, 5,  {32'h58, 32'h57, 32'h56, 32'h55}};
    vecs[3] = '{32'h0000_2000, 1, 0, 32'hDEAD_0000, 5,  {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000}};
    vecs[4] = '{32'h0000_1238, 1, 0, 32'h0000_00A0, 5,  {32'hA3, 32'hA2, 32'hA1, 32'hA0}};

    Rst_n     = 1'b0;
    readmiss  = 1'b0;
    address   = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    prev_line = '0;
    repeat (3) @(negedge Clk);
    check("rst_readready", readready, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_data", datareadmiss, 0);
    check("rst_mem_addr", mem_addr, 0);
    Rst_n = 1'b1;
    @(negedge Clk);

    // Directed table: basic, stalled, handshake lag, follow-on miss, offset address.
    for (int v = 0; v < 5; v++) begin
      run_fill(vecs[v].addr, vecs[v].period, vecs[v].hold, vecs[v].seed, 1'b0, t_ready);
      check("ready_cycle", t_ready, vecs[v].exp_ready);
      check("table_line", datareadmiss, vecs[v].exp_line);
    end

    // Reset in the middle of a fill, after two acks.
    readmiss  = 1'b1;
    address   = 32'h0000_3000;
    mem_ack   = 1'b1;
    mem_rdata = 32'h77;
    repeat (3) @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    check("midrst_req", mem_req, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", readready, 0);
    check("midrst_data", datareadmiss, 0);
    mem_ack  = 1'b0;
    readmiss = 1'b0;
    repeat (2) begin
      @(negedge Clk);
      check("midrst_noready", readready, 0);
    end
    Rst_n     = 1'b1;
    prev_line = '0;
    @(negedge Clk);
    run_fill(32'h0000_3004, 1, 0, 32'h0BAD_F000, 1'b0, t_ready);
    check("post_rst_cycle", t_ready, 5);

    // Readmiss dropped during FETCH still completes the fill.
    run_fill(32'h0000_4444, 2, 0, 32'h1111_0000, 1'b1, t_ready);
    check("drop_early_cycle", t_ready, 9);

    // Randomized fills.
    for (int r = 0; r < 16; r++) begin
      run_fill($urandom, 0, $urandom_range(0, 2), $urandom, ($urandom_range(0, 3) == 0), t_ready);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/icache_refill_responder.md
Name: icache_refill_responder

Overview:
- Memory-side responder for the instruction-cache miss/refill handshake.
- Samples the cache's `readmiss` request and line `address`, then fetches one full line as sequential 32-bit word reads over a req/ack main-memory port.
- Assembles the words into a 128-bit line and returns it on `datareadmiss`, qualified by a one-cycle `readready` pulse.
- Sits between the icache and main memory; the icache is the initiator, this block is the responder.

Parameters:
- LINE_WORDS, 4: words per cache line. Must be a power of two, 2 or greater. Line width = 32*LINE_WORDS. Word-offset bits = log2(LINE_WORDS).
- ADDR_W, 32: byte-address width of the cache and memory interfaces.

Ports:
- Clk  in  1  single clock; all state changes on rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- readmiss  in  1  miss request from icache; level-held until `readready` is seen.
- address  in  ADDR_W  byte address of missing instruction; valid while `readmiss`=1.
- readready  out  1  one-cycle pulse: `datareadmiss` holds the requested line.
- datareadmiss  out  32*LINE_WORDS  refilled line; word i in bits [32i+31:32i].
- busy  out  1  high in any state other than IDLE.
- mem_req  out  1  word read request to main memory.
- mem_addr  out  ADDR_W  word-aligned read address (bits [1:0]=0).
- mem_ack  in  1  memory returns `mem_rdata` this cycle; consumes the current request.
- mem_rdata  in  32  read data, valid when `mem_ack`=1.

Behaviour:
- Reset (Rst_n=0, async): state=IDLE. `readready`, `busy`, `mem_req` = 0. `mem_addr`, `datareadmiss`, word counter and latched base = 0. Asserting reset mid-fill aborts the fill immediately; no `readready` is issued.
- States: IDLE, FETCH, RESP, WAIT_DROP.
- IDLE:
  - If `readmiss`=1, latch line base = `address` with word-offset and byte bits cleared.
  - Latch start offset (0, or see optional feature).
  - Load counter=0 and go to FETCH.
- FETCH:
  - `mem_req`=1 continuously.
  - `mem_addr` = base + (((start+cnt) mod LINE_WORDS) << 2).
  - On `mem_ack`: write `mem_rdata` into line slot (start+cnt) mod LINE_WORDS, increment cnt. `mem_addr` advances on the next cycle.
  - After the LINE_WORDS-th ack: `mem_req` drops in that same next edge; go to RESP.
  - `mem_ack` while `mem_req`=0 is ignored.
- RESP:
  - `readready`=1 for exactly one cycle.
  - `datareadmiss` is registered and already stable. It stays stable until the next fill's final ack overwrites it (slots are written into a staging register; `datareadmiss` updates only on entry to RESP).
  - Next state is WAIT_DROP.
- WAIT_DROP: when `readmiss`=0, go to IDLE. A still-high `readmiss` is never re-served as a new request. This guards against the icache's one-edge lag.
- Minimum latency, with `mem_ack` tied high: `readmiss` sampled at edge 0, FETCH for edges 1..LINE_WORDS, `readready` high in cycle LINE_WORDS+1 (cycle 5 for the default).
- `readmiss` dropping during FETCH does not abort the fill. The fill completes, `readready` pulses, and WAIT_DROP exits immediately.
- `address` changes after latch are ignored until the next IDLE acceptance.
- Counter width is log2(LINE_WORDS)+1; the offset sum wraps modulo LINE_WORDS.

Optional Feature:
- Macro: CRITICAL_WORD_FIRST_EN.
- Defined: start offset = `address` word-offset bits. Words are fetched in wrap order beginning at the requested word (e.g. offset 2 → words 2,3,0,1). Slot placement is unchanged, so the `datareadmiss` layout is identical.
- Undefined: start offset is always 0; words are fetched 0..LINE_WORDS-1.
- Fill latency is identical either way.

Test Plan:
- Reset check: hold Rst_n=0 for 3 cycles → `readready`=0, `mem_req`=0, `busy`=0, `datareadmiss`=0.
- Basic fill: `readmiss`=1, `address`=0x0000_1234, `mem_ack` tied high, memory returns 0xA0+index →
  - `mem_addr` sequence 0x1230, 0x1234, 0x1238, 0x123C;
  - `readready` pulse in cycle 5;
  - `datareadmiss` = {0xA3,0xA2,0xA1,0xA0} per word.
- Stalled memory: `mem_ack` asserted only every 3rd cycle → `mem_addr` holds each word until acked; `readready` after the 4th ack; no duplicated or skipped words.
- Handshake lag: keep `readmiss`=1 for 2 cycles after `readready` → block stays in WAIT_DROP with `mem_req`=0. A new miss at 0x2000 after `readmiss` low for one cycle is served correctly.
- Reset mid-fill: assert Rst_n=0 after 2 acks → no `readready`, `mem_req`=0 at once. A following clean fill returns the correct data.
- With CRITICAL_WORD_FIRST_EN, `address`=0x1238 → `mem_addr` order 0x1238, 0x123C, 0x1230, 0x1234; `datareadmiss` layout matches the basic-fill case.
